// File: rtl/pll_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   state_t   : sequencer state encodings (also driven out on state_dbg)
//   RELOCK_W  : width of the saturating lock-loss counter
//   sat_inc   : saturating increment used by that counter
package pll_pkg;

  localparam int RELOCK_W = 8;

  typedef enum logic [2:0] {
    ST_RESTART   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//   i_clk   : destination clock
//   i_rst_n : async active-low reset, both flops clear to 0
//   i_d     : asynchronous input
//   o_q     : synchronised output, two i_clk cycles of latency
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL restart / lock qualification / staged domain reset release.
//   clkin        : reference clock, the only clock
//   rst_n        : async active-low reset
//   pll_locked   : raw PLL lock, asynchronous to clkin
//   pll_rst      : active-high PLL reset drive
//   rst_out_n    : per-domain active-low resets, released in index order
//   all_ready    : high only in RUN
//   lock_lost    : one-cycle pulse when lock drops during RELEASE or RUN
//   relock_count : saturating count of lock_lost pulses
//   state_dbg    : current state encoding
//
// state      | meaning
// RESTART    | pll_rst held high for RESTART_PULSE cycles
// WAIT_LOCK  | waiting for lock, restarts the PLL after LOCK_TIMEOUT cycles
// STABLE     | lock must hold for STABLE_CYCLES consecutive cycles
// RELEASE    | domains released one every STAGE_GAP cycles
// RUN        | all domains out of reset
module pll_reset_sequencer
  import pll_pkg::*;
#(
  parameter int N_DOMAINS     = 4,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_GAP     = 16,
  parameter int LOCK_TIMEOUT  = 1048576,
  parameter int RESTART_PULSE = 8
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic                 pll_locked,
  output logic                 pll_rst,
  output logic [N_DOMAINS-1:0] rst_out_n,
  output logic                 all_ready,
  output logic                 lock_lost,
  output logic [RELOCK_W-1:0]  relock_count,
  output logic [2:0]           state_dbg
);

  localparam int RP_W  = (RESTART_PULSE > 1) ? $clog2(RESTART_PULSE) : 1;
  localparam int TO_W  = $clog2(LOCK_TIMEOUT);
  localparam int ST_W  = $clog2(STABLE_CYCLES);
  localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int DOM_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  // Counters run from 0 to the "last" value and terminate on equality,
  // so each phase lasts exactly the parameterised number of cycles.
  localparam logic [RP_W-1:0]  RP_LAST  = RP_W'(RESTART_PULSE - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);
  localparam logic [DOM_W-1:0] DOM_LAST = DOM_W'(N_DOMAINS - 1);

  logic w_locked;

  state_t               r_state,     w_state_nxt;
  logic [RP_W-1:0]      r_rp_cnt,    w_rp_nxt;
  logic [TO_W-1:0]      r_to_cnt,    w_to_nxt;
  logic [ST_W-1:0]      r_st_cnt,    w_st_nxt;
  logic [GAP_W-1:0]     r_gap_cnt,   w_gap_nxt;
  logic [DOM_W-1:0]     r_dom,       w_dom_nxt;
  logic                 r_pll_rst,   w_pll_rst_nxt;
  logic [N_DOMAINS-1:0] r_rst_out_n, w_rst_out_nxt;
  logic                 r_ready,     w_ready_nxt;
  logic                 r_lost,      w_lost_nxt;
  logic [RELOCK_W-1:0]  r_relock,    w_relock_nxt;
  logic [N_DOMAINS-1:0] w_rel_mask;

  sync_2ff u_lock_sync (
    .i_clk   (clkin),
    .i_rst_n (rst_n),
    .i_d     (pll_locked),
    .o_q     (w_locked)
  );

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESTART;
      r_rp_cnt    <= '0;
      r_to_cnt    <= '0;
      r_st_cnt    <= '0;
      r_gap_cnt   <= '0;
      r_dom       <= '0;
      r_pll_rst   <= 1'b1;
      r_rst_out_n <= '0;
      r_ready     <= 1'b0;
      r_lost      <= 1'b0;
      r_relock    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rp_cnt    <= w_rp_nxt;
      r_to_cnt    <= w_to_nxt;
      r_st_cnt    <= w_st_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_dom       <= w_dom_nxt;
      r_pll_rst   <= w_pll_rst_nxt;
      r_rst_out_n <= w_rst_out_nxt;
      r_ready     <= w_ready_nxt;
      r_lost      <= w_lost_nxt;
      r_relock    <= w_relock_nxt;
    end
  end

  // Outputs are registered: every w_*_nxt output value describes the
  // state being entered, so outputs change on the same edge as r_state.
  always_comb begin
    w_state_nxt   = r_state;
    w_rp_nxt      = r_rp_cnt;
    w_to_nxt      = r_to_cnt;
    w_st_nxt      = r_st_cnt;
    w_gap_nxt     = r_gap_cnt;
    w_dom_nxt     = r_dom;
    w_pll_rst_nxt = 1'b0;
    w_rst_out_nxt = '0;
    w_ready_nxt   = 1'b0;
    w_lost_nxt    = 1'b0;
    w_relock_nxt  = r_relock;

    // Domains 0 .. r_dom+1 released: the mask after the next stage step.
    w_rel_mask = '0;
    for (int i = 0; i < N_DOMAINS; i++) begin
      w_rel_mask[i] = (i <= int'(r_dom) + 1);
    end

    case (r_state)
      ST_RESTART: begin
        if (r_rp_cnt == RP_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_rp_nxt    = '0;
          w_to_nxt    = '0;
        end else begin
          w_rp_nxt      = r_rp_cnt + 1'b1;
          w_pll_rst_nxt = 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        if (w_locked) begin
          w_state_nxt = ST_STABLE;
          w_st_nxt    = '0;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt   = ST_RESTART;
          w_rp_nxt      = '0;
          w_to_nxt      = '0;
          w_pll_rst_nxt = 1'b1;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end

      // The timeout counter is held here, so a lock that keeps glitching
      // still runs out the WAIT_LOCK budget and restarts the PLL.
      ST_STABLE: begin
        if (!w_locked) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_st_cnt == ST_LAST) begin
          w_state_nxt      = ST_RELEASE;
          w_dom_nxt        = '0;
          w_gap_nxt        = '0;
          w_rst_out_nxt    = '0;
          w_rst_out_nxt[0] = 1'b1;
        end else begin
          w_st_nxt = r_st_cnt + 1'b1;
        end
      end

      // Lock loss is tested first so it beats a stage release due on
      // the same edge.
      ST_RELEASE, ST_RUN: begin
        if (!w_locked) begin
          w_state_nxt  = ST_WAIT_LOCK;
          w_to_nxt     = '0;
          w_lost_nxt   = 1'b1;
          w_relock_nxt = sat_inc(r_relock);
        end else if (r_state == ST_RUN || r_dom == DOM_LAST) begin
          w_state_nxt   = ST_RUN;
          w_rst_out_nxt = '1;
          w_ready_nxt   = 1'b1;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_dom_nxt     = r_dom + 1'b1;
          w_gap_nxt     = '0;
          w_rst_out_nxt = w_rel_mask;
        end else begin
          w_gap_nxt     = r_gap_cnt + 1'b1;
          w_rst_out_nxt = r_rst_out_n;
        end
      end

      default: begin
        w_state_nxt   = ST_RESTART;
        w_rp_nxt      = '0;
        w_pll_rst_nxt = 1'b1;
      end
    endcase
  end

  assign pll_rst      = r_pll_rst;
  assign rst_out_n    = r_rst_out_n;
  assign all_ready    = r_ready;
  assign lock_lost    = r_lost;
  assign relock_count = r_relock;
  assign state_dbg    = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
// Inputs are driven and outputs sampled on the falling edge of clkin;
// "cycle k" is the period after the k-th rising edge following reset release.
module tb_pll_reset_sequencer;

  localparam int ND = 4;
  localparam int SC = 8;
  localparam int SG = 4;
  localparam int LT = 64;
  localparam int RP = 4;

  logic          clkin      = 1'b0;
  logic          rst_n      = 1'b0;
  logic          pll_locked = 1'b0;
  logic          pll_rst;
  logic [ND-1:0] rst_out_n;
  logic          all_ready;
  logic          lock_lost;
  logic [7:0]    relock_count;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int exp_cnt  = 0;

  always #5 clkin = ~clkin;

  pll_reset_sequencer #(
    .N_DOMAINS     (ND),
    .STABLE_CYCLES (SC),
    .STAGE_GAP     (SG),
    .LOCK_TIMEOUT  (LT),
    .RESTART_PULSE (RP)
  ) dut (
    .clkin        (clkin),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .rst_out_n    (rst_out_n),
    .all_ready    (all_ready),
    .lock_lost    (lock_lost),
    .relock_count (relock_count),
    .state_dbg    (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic next();
    @(negedge clkin);
    cyc++;
  endtask

  task automatic wait_state(input logic [2:0] target, input int limit, input string tag);
    int k = 0;
    while (state_dbg !== target && k < limit) begin
      next();
      k++;
    end
    chk(tag, 32'(state_dbg), 32'(target));
  endtask

  task automatic wait_lost(input int limit, input string tag);
    int k = 0;
    while (lock_lost !== 1'b1 && k < limit) begin
      next();
      k++;
    end
    chk(tag, 32'(lock_lost), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_rst_out"}, 32'(rst_out_n), 32'd0);
    chk({tag, "_ready"},   32'(all_ready), 32'd0);
    chk({tag, "_lost"},    32'(lock_lost), 32'd0);
    chk({tag, "_relock"},  32'(relock_count), 32'd0);
    chk({tag, "_state"},   32'(state_dbg), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e_rst;
    logic [2:0] e_st;

    // Power-on reset values
    repeat (2) @(negedge clkin);
    chk_reset_vals("por");

    // Release, lock raised in cycle 10: locked seen in 12, STABLE 13..20,
    // RELEASE at 21, bits at 21/25/29/33, RUN at 34.
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k == 10) pll_locked = 1'b1;
      e_rst = {k >= 33, k >= 29, k >= 25, k >= 21};
      e_st  = (k < 4) ? 3'd0 : (k < 13) ? 3'd1 : (k < 21) ? 3'd2 : (k < 34) ? 3'd3 : 3'd4;
      chk("seq_pll_rst", 32'(pll_rst), 32'(k < 4));
      chk("seq_rst_out", 32'(rst_out_n), 32'(e_rst));
      chk("seq_ready",   32'(all_ready), 32'(k >= 34));
      chk("seq_state",   32'(state_dbg), 32'(e_st));
      if (k != 40) next();
    end

    // Lock loss in RUN: visible to the FSM two cycles later, outputs drop one after.
    pll_locked = 1'b0;
    next();
    chk("run_loss_hold1", 32'(rst_out_n), 32'hF);
    chk("run_loss_lost1", 32'(lock_lost), 32'd0);
    next();
    chk("run_loss_hold2", 32'(rst_out_n), 32'hF);
    next();
    chk("run_loss_rst_out", 32'(rst_out_n), 32'd0);
    chk("run_loss_pulse",   32'(lock_lost), 32'd1);
    chk("run_loss_ready",   32'(all_ready), 32'd0);
    chk("run_loss_count",   32'(relock_count), 32'd1);
    chk("run_loss_state",   32'(state_dbg), 32'd1);
    next();
    chk("run_loss_pulse_end", 32'(lock_lost), 32'd0);
    chk("run_loss_count_hold", 32'(relock_count), 32'd1);

    // Relock with a 3-cycle dropout during STABLE; stability count restarts.
    pll_locked = 1'b1;
    for (int j = 0; j <= 32; j++) begin
      if (j == 5) pll_locked = 1'b0;
      if (j == 8) pll_locked = 1'b1;
      e_st  = (j < 3) ? 3'd1 : (j < 8) ? 3'd2 : (j < 11) ? 3'd1 :
              (j < 19) ? 3'd2 : (j < 32) ? 3'd3 : 3'd4;
      e_rst = {j >= 31, j >= 27, j >= 23, j >= 19};
      chk("stable_drop_state",   32'(state_dbg), 32'(e_st));
      chk("stable_drop_rst_out", 32'(rst_out_n), 32'(e_rst));
      chk("stable_drop_lost",    32'(lock_lost), 32'd0);
      next();
    end
    chk("stable_drop_ready", 32'(all_ready), 32'd1);

    // Loss from RUN again, then relock and drop so the loss lands on bit 2's release edge.
    pll_locked = 1'b0;
    repeat (3) next();
    chk("loss2_count", 32'(relock_count), 32'd2);
    pll_locked = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      chk("bit2_pre_state", 32'(state_dbg), (j < 3) ? 32'd1 : 32'd2);
      next();
    end
    chk("bit2_T_state",   32'(state_dbg), 32'd3);
    chk("bit2_T_rst_out", 32'(rst_out_n), 32'h1);
    repeat (4) next();
    chk("bit2_T4_rst_out", 32'(rst_out_n), 32'h3);
    next();
    pll_locked = 1'b0;
    repeat (2) next();
    chk("bit2_T7_rst_out", 32'(rst_out_n), 32'h3);
    next();
    chk("bit2_T8_rst_out", 32'(rst_out_n), 32'h0);
    chk("bit2_T8_lost",    32'(lock_lost), 32'd1);
    chk("bit2_T8_count",   32'(relock_count), 32'd3);
    chk("bit2_T8_state",   32'(state_dbg), 32'd1);

    // Saturation of relock_count over 300 more loss events.
    exp_cnt = 3;
    for (int e = 0; e < 300; e++) begin
      pll_locked = 1'b1;
      wait_state(3'd3, 40, "sat_reach_release");
      pll_locked = 1'b0;
      wait_lost(10, "sat_lost_pulse");
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk("sat_count", 32'(relock_count), 32'(exp_cnt));
    end
    chk("sat_final", 32'(relock_count), 32'd255);

    // Asynchronous reset in the middle of RELEASE, checked before any clock edge.
    pll_locked = 1'b1;
    wait_state(3'd3, 40, "arst_reach_release");
    next();
    chk("arst_pre_rst_out", 32'(rst_out_n), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");

    // Lock never arrives: 4-cycle pll_rst pulse every 68 cycles.
    pll_locked = 1'b0;
    next();
    chk_reset_vals("arst_held");
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k <= 140; k++) begin
      chk("nolock_pll_rst", 32'(pll_rst), 32'((k % 68) < 4));
      chk("nolock_rst_out", 32'(rst_out_n), 32'd0);
      chk("nolock_state",   32'(state_dbg), ((k % 68) < 4) ? 32'd0 : 32'd1);
      if (k != 140) next();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
